// File: rtl/transaction_sequencer.sv
// transaction_sequencer: steps a transaction through NUM_STEPS travel/execute phase pairs, with a watchdog, abort and failure reporting
module transaction_sequencer #(
  parameter int NUM_STEPS   = 4,
  parameter int STEP_W      = 3,
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_CYC = 200,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start_transaction,
  input  logic              done_travel,
  input  logic              done_step,
  input  logic              step_fail,
  input  logic              abort,
  output logic [STEP_W-1:0] step,
  output logic [STEP_W-1:0] travel,
  output logic              busy,
  output logic              finished_transaction,
  output logic              failed,
  output logic [1:0]        fail_code,
  output logic [STEP_W-1:0] fail_step,
  output logic [CNT_W-1:0]  txn_count
);
  typedef enum logic [2:0] {S_IDLE, S_TRAVEL, S_EXEC, S_DONE, S_FAIL} state_t;
  localparam logic [STEP_W-1:0]    LAST_STEP = STEP_W'(NUM_STEPS);
  localparam logic [TIMEOUT_W-1:0] WD_LAST   = TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam bit                   WD_EN     = TIMEOUT_CYC != 0;
  state_t                r_state, w_next;
  logic [STEP_W-1:0]     r_idx, w_idx;
  logic [TIMEOUT_W-1:0]  r_wd;
  logic [1:0]            w_code;
  logic                  w_timeout, w_phase, w_accept;
  always_comb begin
    w_next    = r_state;
    w_idx     = r_idx;
    w_code    = 2'b00;
    w_timeout = WD_EN && (r_wd == WD_LAST);
    w_accept  = (r_state == S_IDLE) && start_transaction;
    case (r_state)
      S_IDLE: begin
        w_next = start_transaction ? S_TRAVEL : S_IDLE;
        w_idx  = start_transaction ? STEP_W'(1) : '0;
      end
      S_TRAVEL: begin
        w_next = (abort || (!done_travel && w_timeout)) ? S_FAIL : done_travel ? S_EXEC : S_TRAVEL;
        w_code = abort ? 2'b11 : 2'b10;
      end
      S_EXEC: begin
        w_code = abort ? 2'b11 : step_fail ? 2'b01 : 2'b10;
        if (abort || step_fail)
          w_next = S_FAIL;
        else if (done_step) begin
          w_next = (r_idx == LAST_STEP) ? S_DONE : S_TRAVEL;
          w_idx  = (r_idx == LAST_STEP) ? r_idx : r_idx + 1'b1;
        end else if (w_timeout)
          w_next = S_FAIL;
      end
      default: begin
        w_next = S_IDLE;
        w_idx  = '0;
      end
    endcase
    w_phase = (w_next == S_TRAVEL) || (w_next == S_EXEC);
  end
  // outputs are flopped from the next-state decode so they line up with r_state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state              <= S_IDLE;
      r_idx                <= '0;
      r_wd                 <= '0;
      step                 <= '0;
      travel               <= '0;
      busy                 <= 1'b0;
      finished_transaction <= 1'b0;
      failed               <= 1'b0;
      fail_code            <= '0;
      fail_step            <= '0;
      txn_count            <= '0;
    end else begin
      r_state              <= w_next;
      r_idx                <= w_idx;
      r_wd                 <= (w_phase && w_next == r_state) ? r_wd + 1'b1 : '0;
      step                 <= w_phase ? w_idx : '0;
      travel               <= (w_next == S_TRAVEL) ? w_idx : '0;
      busy                 <= w_next != S_IDLE;
      finished_transaction <= w_next == S_DONE;
      failed               <= w_next == S_FAIL;
      if (w_accept) begin
        fail_code <= '0;
        fail_step <= '0;
      end else if (w_next == S_FAIL) begin
        fail_code <= w_code;
        fail_step <= r_idx;
      end
      if (w_next == S_DONE)
        txn_count <= txn_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_transaction_sequencer.sv
// tb_transaction_sequencer: scoreboard bench for transaction_sequencer (4-step and 1-step instances)
module tb_transaction_sequencer;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic       resetn, start, dt, ds, sf, ab;
  logic [2:0] step, travel, fail_step;
  logic       busy, fin, failed;
  logic [1:0] fail_code, txn_count;
  logic       b_start, b_dt, b_ds;
  logic [2:0] b_step, b_travel, b_fstep;
  logic       b_busy, b_fin, b_failed;
  logic [1:0] b_code, b_cnt;
  int n_checks = 0, n_errors = 0;
  typedef struct packed {logic fin; logic [1:0] code; logic [2:0] fstep; logic [1:0] cnt;} exp_t;
  exp_t q[$];
  logic [1:0] exp_cnt = 2'd0;
  transaction_sequencer #(.NUM_STEPS(4), .STEP_W(3), .TIMEOUT_W(8), .TIMEOUT_CYC(5), .CNT_W(2)) dut (
    .clock(clock), .resetn(resetn), .start_transaction(start), .done_travel(dt), .done_step(ds),
    .step_fail(sf), .abort(ab), .step(step), .travel(travel), .busy(busy),
    .finished_transaction(fin), .failed(failed), .fail_code(fail_code), .fail_step(fail_step),
    .txn_count(txn_count));
  transaction_sequencer #(.NUM_STEPS(1), .STEP_W(3), .TIMEOUT_W(8), .TIMEOUT_CYC(5), .CNT_W(2)) dut1 (
    .clock(clock), .resetn(resetn), .start_transaction(b_start), .done_travel(b_dt), .done_step(b_ds),
    .step_fail(1'b0), .abort(1'b0), .step(b_step), .travel(b_travel), .busy(b_busy),
    .finished_transaction(b_fin), .failed(b_failed), .fail_code(b_code), .fail_step(b_fstep),
    .txn_count(b_cnt));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clock);
  endtask
  task automatic push_ok();
    exp_cnt = exp_cnt + 2'd1;
    q.push_back('{1'b1, 2'b00, 3'd0, exp_cnt});
  endtask
  task automatic push_fail(input logic [1:0] code, input logic [2:0] st);
    q.push_back('{1'b0, code, st, exp_cnt});
  endtask
  task automatic start_txn();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask
  task automatic do_travel(input int s, input int w);
    chk("travel", travel, s);
    chk("travel_step", step, s);
    repeat (w) cyc();
    dt = 1'b1;
    cyc();
    dt = 1'b0;
  endtask
  task automatic do_exec(input int s, input int w);
    chk("exec_travel", travel, 0);
    chk("exec_step", step, s);
    repeat (w) cyc();
    ds = 1'b1;
    cyc();
    ds = 1'b0;
  endtask
  always @(negedge clock) begin
    if (resetn && (fin || failed)) begin
      if (q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_fin", fin, e.fin);
        chk("sb_failed", failed, !e.fin);
        chk("sb_code", fail_code, e.code);
        chk("sb_fstep", fail_step, e.fstep);
        chk("sb_cnt", txn_count, e.cnt);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL sim_timeout");
    $fatal(1, "time limit");
  end
  initial begin
    resetn = 1'b0; start = 1'b0; dt = 1'b0; ds = 1'b0; sf = 1'b0; ab = 1'b0;
    b_start = 1'b0; b_dt = 1'b0; b_ds = 1'b0;
    repeat (2) cyc();
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", txn_count, 0);
    chk("rst_code", fail_code, 0);
    resetn = 1'b1;
    cyc();
    ab = 1'b1;
    cyc();
    ab = 1'b0;
    chk("idle_abort", busy, 0);
    // nominal: each done one cycle after entering its phase
    push_ok();
    start_txn();
    chk("nom_busy", busy, 1);
    for (int s = 1; s <= 4; s++) begin
      sf = (s == 2);
      do_travel(s, 1);
      sf = 1'b0;
      do_exec(s, 1);
    end
    chk("nom_done", fin, 1);
    chk("nom_done_step", step, 0);
    cyc();
    chk("nom_idle_busy", busy, 0);
    chk("nom_idle_fin", fin, 0);
    // minimum latency: 8 phase cycles then DONE
    push_ok();
    start_txn();
    for (int s = 1; s <= 4; s++) begin
      do_travel(s, 0);
      do_exec(s, 0);
    end
    chk("lat_done", fin, 1);
    chk("lat_busy", busy, 1);
    cyc();
    // timeout in EXEC step 1
    push_fail(2'b10, 3'd1);
    start_txn();
    do_travel(1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("to_exec", step, 1);
      cyc();
    end
    chk("to_failed", failed, 1);
    cyc();
    chk("to_held_code", fail_code, 2'b10);
    chk("to_idle", busy, 0);
    // done on the last watchdog cycle, plus a start during busy
    push_ok();
    start_txn();
    chk("start_clr_code", fail_code, 0);
    do_travel(1, 4);
    do_exec(1, 4);
    start = 1'b1;
    do_travel(2, 0);
    start = 1'b0;
    do_exec(2, 0);
    for (int s = 3; s <= 4; s++) begin
      do_travel(s, 0);
      do_exec(s, 0);
    end
    chk("wd_done", fin, 1);
    cyc();
    cyc();
    chk("no_queue", busy, 0);
    // step_fail and done_step together in EXEC step 2
    push_fail(2'b01, 3'd2);
    start_txn();
    do_travel(1, 0);
    do_exec(1, 0);
    do_travel(2, 0);
    sf = 1'b1; ds = 1'b1;
    cyc();
    sf = 1'b0; ds = 1'b0;
    chk("sf_failed", failed, 1);
    cyc();
    // abort and done_travel together in TRAVEL step 3
    push_fail(2'b11, 3'd3);
    start_txn();
    for (int s = 1; s <= 2; s++) begin
      do_travel(s, 0);
      do_exec(s, 0);
    end
    ab = 1'b1; dt = 1'b1;
    cyc();
    ab = 1'b0; dt = 1'b0;
    chk("ab_failed", failed, 1);
    cyc();
    chk("ab_held_step", fail_step, 3);
    // asynchronous reset in EXEC step 3
    start_txn();
    for (int s = 1; s <= 2; s++) begin
      do_travel(s, 0);
      do_exec(s, 0);
    end
    do_travel(3, 0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_step", step, 0);
    chk("arst_busy", busy, 0);
    chk("arst_failed", failed, 0);
    chk("arst_code", fail_code, 0);
    cyc();
    chk("arst_nofail", failed, 0);
    resetn = 1'b1;
    exp_cnt = 2'd0;
    cyc();
    push_ok();
    start_txn();
    for (int s = 1; s <= 4; s++) begin
      do_travel(s, 0);
      do_exec(s, 0);
    end
    cyc();
    // start held high: back-to-back transactions and counter wrap
    start = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      push_ok();
      if (k == 3) start = 1'b0;
      for (int s = 1; s <= 4; s++) begin
        do_travel(s, 0);
        do_exec(s, 0);
      end
      chk("b2b_done", fin, 1);
      cyc();
      chk("b2b_idle", busy, 0);
      cyc();
      chk("b2b_next", busy, k < 3);
    end
    chk("wrap_cnt", txn_count, 1);
    // single-step instance
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    chk("one_travel", b_travel, 1);
    chk("one_busy", b_busy, 1);
    b_dt = 1'b1;
    cyc();
    b_dt = 1'b0;
    chk("one_exec_step", b_step, 1);
    chk("one_exec_travel", b_travel, 0);
    b_ds = 1'b1;
    cyc();
    b_ds = 1'b0;
    chk("one_fin", b_fin, 1);
    chk("one_cnt", b_cnt, 1);
    cyc();
    chk("one_idle", b_busy, 0);
    repeat (3) cyc();
    chk("sb_left", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
